// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned DEPTH_WORDS_DEF = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshakes plus the data-memory bus of the arbiter.
interface mem_arbiter_if;

    logic        req0, we0, lock0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, lock1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    logic        mem_RD, mem_WR;
    logic [31:0] mem_DAddr, mem_DataIn, mem_DataOut;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output ack0, err0, rdata0,
        output ack1, err1, rdata1,
        output mem_RD, mem_WR, mem_DAddr, mem_DataIn,
        input  mem_DataOut
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  ack0, err0, rdata0,
        input  ack1, err1, rdata1,
        input  mem_RD, mem_WR, mem_DAddr, mem_DataIn,
        output mem_DataOut
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-request round-robin picker with an optional sticky (locked) port.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic lock_valid,
    input  logic lock_id,
    output logic grant
);

    always_comb begin
        grant = PORT0;
        if (lock_valid && ((lock_id == PORT1) ? req1 : req0)) begin
            grant = lock_id;
        end else if (req0 && req1) begin
            grant = ~last;
        end else if (req1) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-port data memory; IDLE/ACCESS/RESP per transaction.
// Grant locking is compiled in when MEM_ARBITER_LOCK_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input logic          CLK,
    input logic          nReset,
    mem_arbiter_if.slave bus
);

    state_t      state;
    logic        lat_we, lat_id, last, lock_valid, lock_id, lock_now, grant;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_oob, in_access;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last       (last),
        .lock_valid (lock_valid),
        .lock_id    (lock_id),
        .grant      (grant)
    );

`ifdef MEM_ARBITER_LOCK_EN
    assign lock_now = (lat_id == PORT1) ? bus.lock1 : bus.lock0;
`else
    logic unused_lock;
    assign unused_lock = bus.lock0 ^ bus.lock1;
    assign lock_now    = 1'b0;
`endif

    assign lat_oob   = (lat_addr >= DEPTH_WORDS);
    assign in_access = (state == ACCESS);

    // Memory strobes depend only on state and latched registers, so they are glitch-free.
    assign bus.mem_RD     = in_access && !lat_we && !lat_oob;
    assign bus.mem_WR     = in_access &&  lat_we && !lat_oob;
    assign bus.mem_DAddr  = in_access ? lat_addr  : '0;
    assign bus.mem_DataIn = in_access ? lat_wdata : '0;

    always_ff @(posedge CLK) begin
        if (!nReset) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_id     <= PORT0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last       <= PORT1;
            lock_valid <= 1'b0;
            lock_id    <= PORT0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        lat_id     <= grant;
                        lat_we     <= (grant == PORT1) ? bus.we1    : bus.we0;
                        lat_addr   <= (grant == PORT1) ? bus.addr1  : bus.addr0;
                        lat_wdata  <= (grant == PORT1) ? bus.wdata1 : bus.wdata0;
                        last       <= grant;
                        lock_valid <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we && !lat_oob) begin
                        if (lat_id == PORT1) bus.rdata1 <= bus.mem_DataOut;
                        else                 bus.rdata0 <= bus.mem_DataOut;
                    end
                    bus.ack0   <= (lat_id == PORT0);
                    bus.ack1   <= (lat_id == PORT1);
                    bus.err0   <= (lat_id == PORT0) && lat_oob;
                    bus.err1   <= (lat_id == PORT1) && lat_oob;
                    lock_valid <= lock_now;
                    lock_id    <= lat_id;
                    state      <= RESP;
                end
                RESP: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.err0 <= 1'b0;
                    bus.err1 <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
